// File: rtl/rv32i_dtcm_if.sv
// Memory-stage data port plus boot-loader preload port of the data TCM.
interface rv32i_dtcm_if #(
  parameter int WORD_WTH   = 32,
  parameter int ADDR_WTH   = 32,
  parameter int DEPTH_LOG2 = 10
);
  logic [ADDR_WTH-1:0]   dtcm_addr_i;
  logic [WORD_WTH-1:0]   dtcm_wdata_i;
  logic                  dtcm_we_i;
  logic [WORD_WTH-1:0]   dtcm_rdata_o;
  logic                  ld_valid_i;
  logic                  ld_ready_o;
  logic [DEPTH_LOG2-1:0] ld_addr_i;
  logic [WORD_WTH-1:0]   ld_wdata_i;
  logic                  init_done_o;
  logic                  dtcm_err_o;

  modport master (
    output dtcm_addr_i, dtcm_wdata_i, dtcm_we_i, ld_valid_i, ld_addr_i, ld_wdata_i,
    input  dtcm_rdata_o, ld_ready_o, init_done_o, dtcm_err_o
  );

  modport slave (
    input  dtcm_addr_i, dtcm_wdata_i, dtcm_we_i, ld_valid_i, ld_addr_i, ld_wdata_i,
    output dtcm_rdata_o, ld_ready_o, init_done_o, dtcm_err_o
  );
endinterface

// File: rtl/rv32i_dtcm.sv
// Data TCM: zero-clear sweep after reset, then single-cycle word reads/writes plus loader preload.
// Latency: read combinational, writes land at the next posedge; err pulses one cycle after a dropped store.
// Backpressure: loader stalls (ld_ready_o=0) during the sweep and whenever the core stores.
module rv32i_dtcm #(
  parameter int WORD_WTH   = 32,
  parameter int ADDR_WTH   = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input logic         clk,
  input logic         rst,
  rv32i_dtcm_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic                  err_q;
  logic [WORD_WTH-1:0]   mem [DEPTH];

  logic [DEPTH_LOG2-1:0] core_idx;
  logic                  in_range;
  logic                  aligned;
  logic                  core_st;
  logic                  ld_fire;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [WORD_WTH-1:0]   wr_dat;

  assign core_idx = bus.dtcm_addr_i[DEPTH_LOG2+1:2];
  assign in_range = (bus.dtcm_addr_i[ADDR_WTH-1:DEPTH_LOG2+2] == '0);
  assign aligned  = (bus.dtcm_addr_i[1:0] == 2'b00);
  assign core_st  = (state == RUN) && bus.dtcm_we_i && in_range && aligned;
  assign ld_fire  = bus.ld_valid_i && bus.ld_ready_o;

  assign bus.ld_ready_o   = (state == RUN) && !bus.dtcm_we_i;
  assign bus.init_done_o  = (state == RUN);
  assign bus.dtcm_err_o   = err_q;
  assign bus.dtcm_rdata_o = ((state == RUN) && in_range) ? mem[core_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state == RUN) && bus.dtcm_we_i && !(in_range && aligned);
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == '1) state <= RUN;
      end
    end
  end

  // Single write port: sweep, then core store, then loader.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = clr_cnt;
    wr_dat = '0;
    if (state == CLEAR) begin
      wr_en = 1'b1;
    end else if (core_st) begin
      wr_en  = 1'b1;
      wr_idx = core_idx;
      wr_dat = bus.dtcm_wdata_i;
    end else if (ld_fire) begin
      wr_en  = 1'b1;
      wr_idx = bus.ld_addr_i;
      wr_dat = bus.ld_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_idx] <= wr_dat;
  end
endmodule

// File: tb/tb_rv32i_dtcm.sv
// Directed bench for rv32i_dtcm with a 16-word array.
module tb_rv32i_dtcm;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32i_dtcm_if #(.WORD_WTH(32), .ADDR_WTH(32), .DEPTH_LOG2(4)) bus ();

  rv32i_dtcm #(.WORD_WTH(32), .ADDR_WTH(32), .DEPTH_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one posedge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
    bus.dtcm_addr_i  = addr;
    bus.dtcm_wdata_i = wdata;
    bus.dtcm_we_i    = we;
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      #1;
      chk({tag, "_busy"}, {31'd0, bus.init_done_o}, 32'd0);
      step();
    end
    #1;
    chk({tag, "_done"}, {31'd0, bus.init_done_o}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    core(32'h0, 32'h0, 1'b0);
    bus.ld_valid_i = 1'b0;
    bus.ld_addr_i  = '0;
    bus.ld_wdata_i = '0;
    step();
    step();
    #1;
    chk("rst_init_done", {31'd0, bus.init_done_o}, 32'd0);
    chk("rst_ld_ready", {31'd0, bus.ld_ready_o}, 32'd0);
    chk("rst_rdata", bus.dtcm_rdata_o, 32'd0);
    chk("rst_err", {31'd0, bus.dtcm_err_o}, 32'd0);
    rst = 1'b0;

    // Sweep: stores attempted every cycle must be ignored.
    for (int i = 0; i < 16; i++) begin
      core(32'(i * 4), 32'hFFFF_FFFF, 1'b1);
      #1;
      chk("sweep_init_done", {31'd0, bus.init_done_o}, 32'd0);
      chk("sweep_rdata", bus.dtcm_rdata_o, 32'd0);
      chk("sweep_ld_ready", {31'd0, bus.ld_ready_o}, 32'd0);
      chk("sweep_err", {31'd0, bus.dtcm_err_o}, 32'd0);
      step();
    end
    core(32'h3C, 32'h0, 1'b0);
    #1;
    chk("init_done_up", {31'd0, bus.init_done_o}, 32'd1);
    chk("sweep_store_ignored", bus.dtcm_rdata_o, 32'd0);
    chk("sweep_no_err", {31'd0, bus.dtcm_err_o}, 32'd0);

    // Store with read-during-write.
    core(32'h08, 32'hDEAD_BEEF, 1'b1);
    #1;
    chk("rdw_old", bus.dtcm_rdata_o, 32'd0);
    step();
    core(32'h08, 32'h0, 1'b0);
    #1;
    chk("store_visible", bus.dtcm_rdata_o, 32'hDEAD_BEEF);
    chk("store_no_err", {31'd0, bus.dtcm_err_o}, 32'd0);
    core(32'h0C, 32'h0, 1'b0);
    #1;
    chk("neighbour_zero", bus.dtcm_rdata_o, 32'd0);

    // Misaligned store.
    core(32'h0A, 32'h1111_1111, 1'b1);
    step();
    core(32'h08, 32'h0, 1'b0);
    #1;
    chk("misal_err", {31'd0, bus.dtcm_err_o}, 32'd1);
    chk("misal_unchanged", bus.dtcm_rdata_o, 32'hDEAD_BEEF);
    step();
    chk("misal_err_clear", {31'd0, bus.dtcm_err_o}, 32'd0);

    // Out-of-range store (would alias word 0 if decoded wrongly).
    core(32'h40, 32'h2222_2222, 1'b1);
    step();
    core(32'h00, 32'h0, 1'b0);
    #1;
    chk("oor_err", {31'd0, bus.dtcm_err_o}, 32'd1);
    chk("oor_word0", bus.dtcm_rdata_o, 32'd0);
    core(32'h40, 32'h0, 1'b0);
    #1;
    chk("oor_read", bus.dtcm_rdata_o, 32'd0);
    step();
    chk("oor_err_clear", {31'd0, bus.dtcm_err_o}, 32'd0);

    // Read-only access at a bad address never errors.
    core(32'h41, 32'h0, 1'b0);
    step();
    chk("read_bad_no_err", {31'd0, bus.dtcm_err_o}, 32'd0);
    chk("read_bad_zero", bus.dtcm_rdata_o, 32'd0);

    // Loader held off by a core store, then accepted.
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i  = 4'd5;
    bus.ld_wdata_i = 32'h1234_5678;
    core(32'h18, 32'hCAFE_F00D, 1'b1);
    #1;
    chk("ld_blocked", {31'd0, bus.ld_ready_o}, 32'd0);
    step();
    core(32'h18, 32'h0, 1'b0);
    #1;
    chk("core_landed", bus.dtcm_rdata_o, 32'hCAFE_F00D);
    chk("ld_ready", {31'd0, bus.ld_ready_o}, 32'd1);
    core(32'h14, 32'h0, 1'b0);
    #1;
    chk("ld_not_yet", bus.dtcm_rdata_o, 32'd0);
    step();
    bus.ld_valid_i = 1'b0;
    #1;
    chk("ld_landed", bus.dtcm_rdata_o, 32'h1234_5678);

    // Back-to-back stores, last wins.
    core(32'h20, 32'hAAAA_0001, 1'b1);
    step();
    core(32'h20, 32'hBBBB_0002, 1'b1);
    step();
    core(32'h20, 32'h0, 1'b0);
    #1;
    chk("b2b_last", bus.dtcm_rdata_o, 32'hBBBB_0002);

    // Preload every word.
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid_i = 1'b1;
      bus.ld_addr_i  = 4'(i);
      bus.ld_wdata_i = 32'hA500_0000 + 32'(i);
      step();
    end
    bus.ld_valid_i = 1'b0;
    core(32'h1C, 32'h0, 1'b0);
    #1;
    chk("preload_w7", bus.dtcm_rdata_o, 32'hA500_0007);
    core(32'h3C, 32'h0, 1'b0);
    #1;
    chk("preload_w15", bus.dtcm_rdata_o, 32'hA500_000F);

    // Reset in RUN restarts the sweep and wipes the preload.
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rerun_rdata", bus.dtcm_rdata_o, 32'd0);
    chk("rerun_ld_ready", {31'd0, bus.ld_ready_o}, 32'd0);
    sweep_check("rerun");
    for (int i = 0; i < 16; i++) begin
      core(32'(i * 4), 32'h0, 1'b0);
      #1;
      chk("rerun_zero", bus.dtcm_rdata_o, 32'd0);
    end

    // Reset mid-sweep at clr_cnt=7.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep_check("midsweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32i_dtcm.md
Name: rv32i_dtcm

Overview:
Data tightly-coupled memory: the responder on the memory-stage data interface. It serves single-cycle word reads and writes from the pipeline.
- After reset it zero-clears the whole array with an internal sweep FSM.
- It then accepts preload words from a testbench/boot loader over a valid/ready port.
- It flags illegal core stores (misaligned or out-of-range).

Parameters:
WORD_WTH, 32, data word width
ADDR_WTH, 32, byte address width
DEPTH_LOG2, 10, log2 of array depth in words (default 1024 words = 4 KiB)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
dtcm_addr_i  input  ADDR_WTH  byte address from memory stage
dtcm_wdata_i  input  WORD_WTH  store data from memory stage
dtcm_we_i  input  1  store enable from memory stage
dtcm_rdata_o  output  WORD_WTH  read data to memory stage (combinational)
ld_valid_i  input  1  loader word valid
ld_ready_o  output  1  loader word accepted this cycle if valid
ld_addr_i  input  DEPTH_LOG2  loader word index
ld_wdata_i  input  WORD_WTH  loader word data
init_done_o  output  1  clear sweep finished; array usable
dtcm_err_o  output  1  one-cycle pulse: previous-cycle core store was dropped

Behaviour:
- Reset (rst=1 at posedge):
  - state <= CLEAR, clr_cnt <= 0, dtcm_err_o <= 0.
  - Outputs during and right after reset: init_done_o=0, ld_ready_o=0, dtcm_rdata_o=0.
  - rst asserted mid-sweep or mid-run restarts the sweep from index 0. Previously loaded contents are lost (zeroed).
- Address decode, core port:
  - Word index = dtcm_addr_i[DEPTH_LOG2+1:2].
  - in_range = dtcm_addr_i[ADDR_WTH-1:DEPTH_LOG2+2] == 0.
  - aligned = dtcm_addr_i[1:0] == 0.
- FSM state CLEAR:
  - Each cycle writes 0 to array[clr_cnt] and increments clr_cnt.
  - When clr_cnt == DEPTH-1 the write still happens and state <= RUN.
  - The sweep takes exactly 2^DEPTH_LOG2 cycles after rst deasserts. init_done_o=1 from the next cycle onward; it is a pure decode of state==RUN.
  - In CLEAR: core stores ignored, dtcm_err_o stays 0, dtcm_rdata_o forced 0, ld_ready_o=0.
- FSM state RUN (held until rst):
  - Read: dtcm_rdata_o = in_range ? array[index] : 0. Combinational, zero latency, so the memory stage registers it in the same cycle. Issued every cycle regardless of dtcm_we_i; reads never raise errors.
  - Core store: when dtcm_we_i & in_range & aligned, array[index] <= dtcm_wdata_i at posedge.
  - Dropped store: when dtcm_we_i & ~(in_range & aligned), the array is unchanged and dtcm_err_o <= 1 for exactly the next cycle, then 0.
  - Loader port: ld_ready_o = (state==RUN) & ~dtcm_we_i. The core store has priority; loader and core never write the same cycle.
  - Loader write: on ld_valid_i & ld_ready_o, array[ld_addr_i] <= ld_wdata_i. A held ld_valid_i during a core-store cycle waits; no data is lost.
- Read-during-write, same index, same cycle (core or loader): dtcm_rdata_o returns old contents. New data is visible from the next cycle.
- Back-to-back stores to the same index: the last one wins, one per cycle, no stall.
- No byte/halfword enables: stores are full-word only. Sub-word handling is outside this block.
- Implementation: array is a reg array with an asynchronous read port and a single synchronous write port, muxed CLEAR / core / loader in that priority.

Test Plan:
- Use DEPTH_LOG2=4. Assert rst 2 cycles, release -> init_done_o=0 for exactly 16 cycles then 1. During the sweep, dtcm_rdata_o=0, ld_ready_o=0, and we=1 writes have no effect.
- After init: store 0xDEADBEEF @0x08 -> same-cycle read @0x08 returns 0; next-cycle read returns 0xDEADBEEF. Read @0x0C returns 0.
- Store @0x0A (misaligned) and store @0x40 (out of range) -> dtcm_err_o pulses one cycle after each, array unchanged. Read @0x40 returns 0. A read-only access @0x41 gives no error.
- Loader: hold ld_valid_i=1, idx 5, data 0x12345678, while core we=1 in the same cycle -> ld_ready_o=0 and the core write lands. Next cycle, with we=0, ld_ready_o=1 and read @0x14 afterwards returns 0x12345678.
- Load all 16 words, assert rst for 1 cycle in RUN -> sweep restarts, all words read 0 after init_done_o rises again 16 cycles later.
- Reset mid-sweep at clr_cnt=7 -> init_done_o stays 0 a full 16 cycles after rst release.
